// File: rtl/ma_unit_pipe.sv
// ma_unit_pipe: multi-lane 2-stage modular add/sub/neg/pass with valid/ready.
// Optional operand range checking enabled by defining MA_RANGE_CHECK_EN.
module ma_unit_pipe #(
  parameter int DATA_WIDTH = 50,
  parameter int LANES      = 4,
  parameter int TAG_WIDTH  = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [2*LANES-1:0]          in_op,
  input  logic [DATA_WIDTH-1:0]       in_modulus,
  input  logic [DATA_WIDTH*LANES-1:0] in_a,
  input  logic [DATA_WIDTH*LANES-1:0] in_b,
  input  logic [TAG_WIDTH-1:0]        in_tag,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [DATA_WIDTH*LANES-1:0] out_data,
  output logic [TAG_WIDTH-1:0]        out_tag
`ifdef MA_RANGE_CHECK_EN
  ,
  output logic [LANES-1:0]            out_range_err
`endif
);

  localparam int DW = DATA_WIDTH;

  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_SUB  = 2'b01;
  localparam logic [1:0] OP_NEG  = 2'b10;
  localparam logic [1:0] OP_PASS = 2'b11;

  logic                 s1_valid;
  logic [DW-1:0]        s1_q;
  logic [TAG_WIDTH-1:0] s1_tag;
  logic                 s2_adv;
  logic                 accept;
  logic [DW*LANES-1:0]  res_all;
  logic [LANES-1:0]     err_all;

  assign s2_adv   = s1_valid && (!out_valid || out_ready);
  assign in_ready = !s1_valid || s2_adv;
  assign accept   = in_valid && in_ready;

  genvar g;
  for (g = 0; g < LANES; g++) begin : g_lane
    logic [DW:0]   a_x;
    logic [DW:0]   b_x;
    logic [DW:0]   q_x;
    logic [1:0]    op_n;
    logic [DW:0]   raw_n;
    logic          bz_n;
    logic          err_n;
    logic [DW:0]   raw_r;
    logic [1:0]    op_r;
    logic          bz_r;
    logic          err_r;
    logic [DW:0]   qr_x;
    logic [DW:0]   diff;
    logic [DW:0]   sum;
    logic [DW-1:0] red;
    logic          unused_ok;

    assign a_x  = {1'b0, in_a[g*DW +: DW]};
    assign b_x  = {1'b0, in_b[g*DW +: DW]};
    assign q_x  = {1'b0, in_modulus};
    assign op_n = in_op[2*g +: 2];
    assign bz_n = (op_n == OP_NEG) && (b_x == '0);

    // Stage 1: raw value keeps the borrow of a-b in its top bit
    always_comb begin
      raw_n = a_x;
      unique case (op_n)
        OP_ADD:  raw_n = a_x + b_x;
        OP_SUB:  raw_n = a_x - b_x;
        OP_NEG:  raw_n = q_x - b_x;
        OP_PASS: raw_n = a_x;
      endcase
    end

`ifdef MA_RANGE_CHECK_EN
    always_comb begin
      err_n = 1'b0;
      unique case (op_n)
        OP_ADD:  err_n = (a_x >= q_x) || (b_x >= q_x);
        OP_SUB:  err_n = (a_x >= q_x) || (b_x >= q_x);
        OP_NEG:  err_n = (b_x >= q_x);
        OP_PASS: err_n = (a_x >= q_x);
      endcase
    end
`else
    assign err_n = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        raw_r <= '0;
        op_r  <= '0;
        bz_r  <= 1'b0;
        err_r <= 1'b0;
      end else if (accept) begin
        raw_r <= raw_n;
        op_r  <= op_n;
        bz_r  <= bz_n;
        err_r <= err_n;
      end
    end

    assign qr_x = {1'b0, s1_q};
    assign diff = raw_r - qr_x;
    assign sum  = raw_r + qr_x;

    // Stage 2: single conditional correction by q
    always_comb begin
      red = raw_r[DW-1:0];
      unique case (op_r)
        OP_ADD:  red = (raw_r >= qr_x) ? diff[DW-1:0] : raw_r[DW-1:0];
        OP_SUB:  red = raw_r[DW] ? sum[DW-1:0] : raw_r[DW-1:0];
        OP_NEG:  red = bz_r ? '0 : raw_r[DW-1:0];
        OP_PASS: red = raw_r[DW-1:0];
      endcase
    end

    assign unused_ok = &{1'b0, diff[DW], sum[DW]};
    assign res_all[g*DW +: DW] = err_r ? '0 : red;
    assign err_all[g] = err_r;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid <= 1'b0;
      s1_q     <= '0;
      s1_tag   <= '0;
    end else begin
      if (accept) begin
        s1_valid <= 1'b1;
        s1_q     <= in_modulus;
        s1_tag   <= in_tag;
      end else if (s2_adv) begin
        s1_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_tag   <= '0;
    end else if (s2_adv) begin
      out_valid <= 1'b1;
      out_data  <= res_all;
      out_tag   <= s1_tag;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef MA_RANGE_CHECK_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_range_err <= '0;
    end else if (s2_adv) begin
      out_range_err <= err_all;
    end
  end
`else
  logic unused_err;
  assign unused_err = &{1'b0, err_all};
`endif

endmodule

// File: tb/tb_ma_unit_pipe.sv
// tb_ma_unit_pipe: directed bench for ma_unit_pipe with a queue-based model.
// Build with MA_RANGE_CHECK_EN to also cover the range-check port.
module tb_ma_unit_pipe;

  localparam int DW = 50;
  localparam int L  = 4;
  localparam int TW = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [2*L-1:0]  in_op;
  logic [DW-1:0]   in_modulus;
  logic [DW*L-1:0] in_a;
  logic [DW*L-1:0] in_b;
  logic [TW-1:0]   in_tag;
  logic            out_valid;
  logic            out_ready;
  logic [DW*L-1:0] out_data;
  logic [TW-1:0]   out_tag;
`ifdef MA_RANGE_CHECK_EN
  logic [L-1:0]    out_range_err;
`endif

  always #5 clk = ~clk;

  ma_unit_pipe #(.DATA_WIDTH(DW), .LANES(L), .TAG_WIDTH(TW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_modulus(in_modulus),
    .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_tag(out_tag)
`ifdef MA_RANGE_CHECK_EN
    , .out_range_err(out_range_err)
`endif
  );

  typedef struct {
    logic [DW*L-1:0] data;
    logic [TW-1:0]   tag;
    logic [L-1:0]    err;
  } exp_t;

  exp_t mq[$];
  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [255:0] got,
                     input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // Reference: plain modular arithmetic on 64-bit integers
  function automatic logic [63:0] lane_ref(input logic [1:0] op,
    input logic [63:0] q, input logic [63:0] a, input logic [63:0] b);
    case (op)
      2'd0:    return (a + b) % q;
      2'd1:    return (a + q - b) % q;
      2'd2:    return (q - b) % q;
      default: return a;
    endcase
  endfunction

  function automatic exp_t model();
    exp_t e;
    logic [63:0] q, a, b, r;
    logic [1:0] op;
    logic bad;
    e.tag = in_tag;
    e.err = '0;
    e.data = '0;
    q = 64'(in_modulus);
    for (int i = 0; i < L; i++) begin
      op = in_op[2*i +: 2];
      a = 64'(in_a[i*DW +: DW]);
      b = 64'(in_b[i*DW +: DW]);
      bad = 1'b0;
`ifdef MA_RANGE_CHECK_EN
      case (op)
        2'd0, 2'd1: bad = (a >= q) || (b >= q);
        2'd2:       bad = (b >= q);
        default:    bad = (a >= q);
      endcase
`endif
      r = bad ? 64'd0 : lane_ref(op, q, a, b);
      e.err[i] = bad;
      e.data[i*DW +: DW] = r[DW-1:0];
    end
    return e;
  endfunction

  logic            stall_p = 1'b0;
  logic [DW*L-1:0] hold_d;
  logic [TW-1:0]   hold_t;

  always @(negedge clk) begin
    if (!rst) begin
      mq.delete();
      stall_p = 1'b0;
    end else begin
      chk("in_ready", in_ready, !(mq.size() == 2 && !out_ready));
      if (stall_p) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_data", out_data, hold_d);
        chk("stall_tag", out_tag, hold_t);
      end
      if (out_valid) begin
        if (mq.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL spurious_out got tag=%0h exp=none", out_tag);
        end else begin
          chk("out_data", out_data, mq[0].data);
          chk("out_tag", out_tag, mq[0].tag);
`ifdef MA_RANGE_CHECK_EN
          chk("out_err", out_range_err, mq[0].err);
`endif
          if (out_ready) void'(mq.pop_front());
        end
      end
      if (in_valid && in_ready) mq.push_back(model());
      stall_p = out_valid && !out_ready;
      hold_d = out_data;
      hold_t = out_tag;
    end
  end

  task automatic set_lane(input int i, input logic [1:0] op,
                          input logic [63:0] a, input logic [63:0] b);
    in_op[2*i +: 2] = op;
    in_a[i*DW +: DW] = a[DW-1:0];
    in_b[i*DW +: DW] = b[DW-1:0];
  endtask

  task automatic send();
    int n;
    @(posedge clk);
    #1 in_valid = 1'b1;
    @(negedge clk);
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      checks++;
      failures++;
      $display("FAIL send_timeout got in_ready=0 exp=1");
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic expect_out(input string name, input logic [DW*L-1:0] d,
                            input logic [TW-1:0] t);
    int n;
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_valid"}, out_valid, 1);
    chk({name, "_data"}, out_data, d);
    chk({name, "_tag"}, out_tag, t);
  endtask

  function automatic logic [DW*L-1:0] pack4(input logic [63:0] d0,
    input logic [63:0] d1, input logic [63:0] d2, input logic [63:0] d3);
    return {d3[DW-1:0], d2[DW-1:0], d1[DW-1:0], d0[DW-1:0]};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] qw;
    bit pat[6];
    int sent, cyc, stalls;
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    rst = 1'b0;
    in_valid = 1'b1;
    out_ready = 1'b1;
    in_modulus = 50'd97;
    in_tag = 8'hEE;
    in_op = '0;
    in_a = '0;
    in_b = '0;
    for (int i = 0; i < L; i++) set_lane(i, 2'd0, 64'd7, 64'd9);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_tag", out_tag, 0);
    @(posedge clk);
    #1 rst = 1'b1;
    in_valid = 1'b0;

    // Mixed lanes, q=97, with exact latency
    set_lane(0, 2'd0, 64'd90, 64'd10);
    set_lane(1, 2'd1, 64'd5, 64'd20);
    set_lane(2, 2'd2, 64'd3, 64'd0);
    set_lane(3, 2'd3, 64'd42, 64'd11);
    in_tag = 8'h3C;
    send();
    @(negedge clk);
    chk("lat1_valid", out_valid, 0);
    @(negedge clk);
    chk("lat2_valid", out_valid, 1);
    chk("mixed_data", out_data, pack4(3, 82, 0, 42));
    chk("mixed_tag", out_tag, 8'h3C);

    // Wide boundary
    qw = (64'd1 << 50) - 64'd27;
    in_modulus = qw[DW-1:0];
    set_lane(0, 2'd0, qw - 1, qw - 1);
    set_lane(1, 2'd1, 64'd0, qw - 1);
    set_lane(2, 2'd2, 64'd5, 64'd1);
    set_lane(3, 2'd3, qw - 1, 64'd0);
    in_tag = 8'hA5;
    send();
    expect_out("wide", pack4(64'd1125899906842595, 64'd1,
                             64'd1125899906842596, 64'd1125899906842596),
               8'hA5);

    // Smallest modulus
    in_modulus = 50'd2;
    set_lane(0, 2'd0, 64'd1, 64'd1);
    set_lane(1, 2'd1, 64'd0, 64'd1);
    set_lane(2, 2'd2, 64'd0, 64'd1);
    set_lane(3, 2'd3, 64'd1, 64'd0);
    in_tag = 8'h22;
    send();
    expect_out("q2", pack4(0, 1, 1, 1), 8'h22);

    // Back-pressure stream of tags 1..6
    in_modulus = 50'd97;
    sent = 0;
    cyc = 0;
    stalls = 0;
    while (sent < 6 && cyc < 100) begin
      @(posedge clk);
      #1 out_ready = pat[cyc % 6];
      in_valid = 1'b1;
      in_tag = 8'(sent + 1);
      for (int i = 0; i < L; i++)
        set_lane(i, 2'((sent + i) % 4), 64'(((sent + 1) * 13 + i * 7) % 97),
                 64'(((sent + 1) * 29 + i * 11) % 97));
      @(negedge clk);
      if (in_ready) sent++;
      else stalls++;
      cyc++;
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
    chk("bp_sent", sent, 6);
    chk("bp_stalled", stalls > 0, 1);
    while (mq.size() != 0 && cyc < 200) begin
      @(posedge clk);
      #1 out_ready = pat[cyc % 6];
      cyc++;
      @(negedge clk);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("bp_drain", mq.size(), 0);

    // Reset with two transactions in flight
    out_ready = 1'b0;
    in_tag = 8'h50;
    send();
    in_tag = 8'h51;
    send();
    @(negedge clk);
    chk("rst_inflight", mq.size(), 2);
    @(posedge clk);
    #3 rst = 1'b0;
    #1 chk("rst_async", out_valid, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    out_ready = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("no_stale", out_valid, 0);
    end
    set_lane(0, 2'd1, 64'd10, 64'd3);
    set_lane(1, 2'd2, 64'd0, 64'd96);
    set_lane(2, 2'd0, 64'd50, 64'd50);
    set_lane(3, 2'd3, 64'd77, 64'd1);
    in_tag = 8'h60;
    send();
    expect_out("post_rst", pack4(7, 1, 3, 77), 8'h60);

`ifdef MA_RANGE_CHECK_EN
    set_lane(0, 2'd0, 64'd97, 64'd1);
    set_lane(1, 2'd1, 64'd3, 64'd2);
    set_lane(2, 2'd3, 64'd5, 64'd200);
    set_lane(3, 2'd3, 64'd5, 64'd0);
    in_tag = 8'h77;
    send();
    expect_out("range", pack4(0, 1, 5, 5), 8'h77);
    chk("range_err", out_range_err, 4'b0001);
`endif

    repeat (4) @(negedge clk);
    chk("final_empty", mq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
